// File: rtl/sobel_gcd_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sobel_gcd_sched : command scheduler for the GCD and Sobel pixel engines.
// Optional watchdog abort enabled by defining SCHED_TIMEOUT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module sobel_gcd_sched #(
  parameter int DATA_WIDTH     = 16,
  parameter int PIXEL_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_i,
  input  logic                   nreset_i,
  input  logic                   cmd_valid_i,
  input  logic [15:0]            cmd_i,
  output logic [DATA_WIDTH-1:0]  operand_a_o,
  output logic [DATA_WIDTH-1:0]  operand_b_o,
  output logic                   gcd_enable_o,
  input  logic [DATA_WIDTH-1:0]  gcd_i,
  input  logic                   gcd_done_i,
  output logic                   prep_allowed_o,
  output logic [PIXEL_WIDTH-1:0] input_px_gray_o,
  input  logic [PIXEL_WIDTH-1:0] output_px_sobel_i,
  input  logic                   pixel_completed_i,
  input  logic                   prep_completed_i,
  output logic [15:0]            tx_data_o,
  output logic                   result_valid_o
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_GCD_RUN   = 2'd1,
    S_SOBEL_RUN = 2'd2
  } state_t;

  localparam logic [7:0] C_ADDR_A_LO   = 8'h20;
  localparam logic [7:0] C_ADDR_A_HI   = 8'h21;
  localparam logic [7:0] C_ADDR_B_LO   = 8'h22;
  localparam logic [7:0] C_ADDR_B_HI   = 8'h23;
  localparam logic [7:0] C_ADDR_GCD    = 8'h24;
  localparam logic [7:0] C_ADDR_SOBEL  = 8'h30;
  localparam logic [7:0] C_ADDR_STATUS = 8'h40;

  if (DATA_WIDTH != 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("sobel_gcd_sched: DATA_WIDTH must be 16 and TIMEOUT_CYCLES >= 2");
  end

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
  logic [PIXEL_WIDTH-1:0] px_q, px_d;
  logic                   gcd_en_q, gcd_en_d, prep_q, prep_d;
  logic [15:0]            tx_q, tx_d;
  logic                   rv_q, rv_d;
  logic                   busy_err_q, busy_err_d, timeout_q, timeout_d;
  logic                   bad_addr_q, bad_addr_d, frame_done_q, frame_done_d;

  logic                   idle, status_rd, sticky_clr, expired;
  logic                   busy_err_set, bad_addr_set, timeout_set;
  logic [7:0]             cmd_addr, cmd_pl;
  logic [15:0]            status_word;

`ifdef SCHED_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] timer_q, timer_d;

  // Held at zero while idle, so every job starts counting from zero.
  always_comb begin
    timer_d = (state_q == S_IDLE) ? '0 : timer_q + 1'b1;
    expired = (state_q != S_IDLE) && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) timer_q <= '0;
    else           timer_q <= timer_d;
  end
`else
  always_comb expired = 1'b0;
`endif

  always_comb begin
    cmd_addr    = cmd_i[15:8];
    cmd_pl      = cmd_i[7:0];
    idle        = (state_q == S_IDLE);
    status_word = {8'h40, 2'b00, frame_done_q, bad_addr_q, timeout_q, busy_err_q,
                   state_q == S_SOBEL_RUN, state_q == S_GCD_RUN};
  end

  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    px_d         = px_q;
    gcd_en_d     = gcd_en_q;
    prep_d       = prep_q;
    tx_d         = tx_q;
    rv_d         = 1'b0;
    status_rd    = 1'b0;
    busy_err_set = 1'b0;
    bad_addr_set = 1'b0;
    timeout_set  = 1'b0;

    // Commands are judged against the registered state only.
    if (cmd_valid_i) begin
      case (cmd_addr)
        C_ADDR_A_LO:   if (idle) op_a_d[7:0]  = cmd_pl; else busy_err_set = 1'b1;
        C_ADDR_A_HI:   if (idle) op_a_d[15:8] = cmd_pl; else busy_err_set = 1'b1;
        C_ADDR_B_LO:   if (idle) op_b_d[7:0]  = cmd_pl; else busy_err_set = 1'b1;
        C_ADDR_B_HI:   if (idle) op_b_d[15:8] = cmd_pl; else busy_err_set = 1'b1;
        C_ADDR_GCD: begin
          if (idle) begin
            state_d  = S_GCD_RUN;
            gcd_en_d = 1'b1;
          end else busy_err_set = 1'b1;
        end
        C_ADDR_SOBEL: begin
          if (idle) begin
            state_d = S_SOBEL_RUN;
            prep_d  = 1'b1;
            px_d    = PIXEL_WIDTH'(cmd_pl);
          end else busy_err_set = 1'b1;
        end
        C_ADDR_STATUS: status_rd = 1'b1;
        default:       bad_addr_set = 1'b1;
      endcase
    end

    sticky_clr = status_rd;
    if (status_rd) begin
      tx_d = status_word;
      rv_d = 1'b1;
    end

    // An engine result outranks a coincident status read; sticky bits then stay.
    case (state_q)
      S_GCD_RUN: begin
        if (gcd_done_i) begin
          tx_d       = gcd_i;
          rv_d       = 1'b1;
          sticky_clr = 1'b0;
          state_d    = S_IDLE;
          gcd_en_d   = 1'b0;
        end else if (expired) begin
          state_d     = S_IDLE;
          gcd_en_d    = 1'b0;
          timeout_set = 1'b1;
        end
      end
      S_SOBEL_RUN: begin
        if (pixel_completed_i) begin
          tx_d       = {8'h5B, 8'(output_px_sobel_i)};
          rv_d       = 1'b1;
          sticky_clr = 1'b0;
          state_d    = S_IDLE;
          prep_d     = 1'b0;
        end else if (expired) begin
          state_d     = S_IDLE;
          prep_d      = 1'b0;
          timeout_set = 1'b1;
        end
      end
      default: ;
    endcase

    busy_err_d   = (busy_err_q   & ~sticky_clr) | busy_err_set;
    timeout_d    = (timeout_q    & ~sticky_clr) | timeout_set;
    bad_addr_d   = (bad_addr_q   & ~sticky_clr) | bad_addr_set;
    frame_done_d = (frame_done_q & ~sticky_clr) | prep_completed_i;
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q      <= S_IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      px_q         <= '0;
      gcd_en_q     <= 1'b0;
      prep_q       <= 1'b0;
      tx_q         <= '0;
      rv_q         <= 1'b0;
      busy_err_q   <= 1'b0;
      timeout_q    <= 1'b0;
      bad_addr_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      px_q         <= px_d;
      gcd_en_q     <= gcd_en_d;
      prep_q       <= prep_d;
      tx_q         <= tx_d;
      rv_q         <= rv_d;
      busy_err_q   <= busy_err_d;
      timeout_q    <= timeout_d;
      bad_addr_q   <= bad_addr_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign operand_a_o     = op_a_q;
  assign operand_b_o     = op_b_q;
  assign gcd_enable_o    = gcd_en_q;
  assign prep_allowed_o  = prep_q;
  assign input_px_gray_o = px_q;
  assign tx_data_o       = tx_q;
  assign result_valid_o  = rv_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_gcd_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sobel_gcd_sched : directed scoreboard bench for sobel_gcd_sched.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_sobel_gcd_sched;

  logic        clk_i = 1'b0;
  logic        nreset_i;
  logic        cmd_valid_i;
  logic [15:0] cmd_i;
  logic [15:0] operand_a_o, operand_b_o;
  logic        gcd_enable_o;
  logic [15:0] gcd_i;
  logic        gcd_done_i;
  logic        prep_allowed_o;
  logic [7:0]  input_px_gray_o;
  logic [7:0]  output_px_sobel_i;
  logic        pixel_completed_i;
  logic        prep_completed_i;
  logic [15:0] tx_data_o;
  logic        result_valid_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pulse  = 0;
  logic [15:0] sb[$];

  always #5 clk_i = ~clk_i;

  sobel_gcd_sched #(
    .DATA_WIDTH    (16),
    .PIXEL_WIDTH   (8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i            (clk_i),
    .nreset_i         (nreset_i),
    .cmd_valid_i      (cmd_valid_i),
    .cmd_i            (cmd_i),
    .operand_a_o      (operand_a_o),
    .operand_b_o      (operand_b_o),
    .gcd_enable_o     (gcd_enable_o),
    .gcd_i            (gcd_i),
    .gcd_done_i       (gcd_done_i),
    .prep_allowed_o   (prep_allowed_o),
    .input_px_gray_o  (input_px_gray_o),
    .output_px_sobel_i(output_px_sobel_i),
    .pixel_completed_i(pixel_completed_i),
    .prep_completed_i (prep_completed_i),
    .tx_data_o        (tx_data_o),
    .result_valid_o   (result_valid_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [15:0] c);
    cmd_i       = c;
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic status_read(input logic [15:0] exp);
    sb.push_back(exp);
    send(16'h4000);
  endtask

  // Every result pulse consumes exactly one expected word.
  always @(negedge clk_i) begin
    if (nreset_i && result_valid_o) begin
      n_pulse++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL unexpected_result: observed %0h expected no result", tx_data_o);
      end else begin
        check("result", 64'(tx_data_o), 64'(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected test completion");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    int p0;
    int en_cnt;
    nreset_i          = 1'b0;
    cmd_valid_i       = 1'b0;
    cmd_i             = '0;
    gcd_i             = '0;
    gcd_done_i        = 1'b0;
    output_px_sobel_i = '0;
    pixel_completed_i = 1'b0;
    prep_completed_i  = 1'b0;
    repeat (3) tick();
    check("reset_outputs", 64'({operand_a_o, operand_b_o, gcd_enable_o, prep_allowed_o,
                                input_px_gray_o, tx_data_o, result_valid_o}), 64'd0);
    nreset_i = 1'b1;
    tick();

    // GCD job: A=0x30, B=0x12, result 6 after ten cycles.
    send(16'h2030); send(16'h2100); send(16'h2212); send(16'h2300);
    check("operand_a", 64'(operand_a_o), 64'h0030);
    check("operand_b", 64'(operand_b_o), 64'h0012);
    p0 = n_pulse;
    send(16'h2400);
    en_cnt = 0;
    if (gcd_enable_o) en_cnt++;
    repeat (9) begin
      tick();
      if (gcd_enable_o) en_cnt++;
    end
    gcd_i = 16'h0006; gcd_done_i = 1'b1; sb.push_back(16'h0006);
    tick();
    gcd_done_i = 1'b0;
    check("gcd_enable_len", 64'(en_cnt), 64'd10);
    check("gcd_enable_drop", 64'(gcd_enable_o), 64'd0);
    check("gcd_tx", 64'(tx_data_o), 64'h0006);
    repeat (2) tick();
    check("gcd_single_pulse", 64'(n_pulse - p0), 64'd1);

    // Sobel job.
    send(16'h3080);
    check("sobel_prep", 64'(prep_allowed_o), 64'd1);
    check("sobel_px", 64'(input_px_gray_o), 64'h80);
    check("sobel_no_gcd", 64'(gcd_enable_o), 64'd0);
    repeat (3) tick();
    output_px_sobel_i = 8'hC3; pixel_completed_i = 1'b1; sb.push_back(16'h5BC3);
    tick();
    pixel_completed_i = 1'b0;
    check("sobel_prep_drop", 64'(prep_allowed_o), 64'd0);
    check("sobel_tx", 64'(tx_data_o), 64'h5BC3);

    // Commands rejected while busy; status read mid-job.
    send(16'h2400);
    send(16'h30AA);
    send(16'h2055);
    check("busy_op_a", 64'(operand_a_o), 64'h0030);
    check("busy_no_sobel", 64'({prep_allowed_o, input_px_gray_o}), 64'h080);
    check("busy_gcd_running", 64'(gcd_enable_o), 64'd1);
    status_read(16'h4005);
    check("busy_status_keeps_job", 64'(gcd_enable_o), 64'd1);
    gcd_done_i = 1'b1; sb.push_back(16'h0006);
    tick();
    gcd_done_i = 1'b0;
    status_read(16'h4000);

    // Command coincident with done: done honoured, command rejected.
    send(16'h2400);
    tick();
    gcd_i = 16'h0009; gcd_done_i = 1'b1; sb.push_back(16'h0009);
    cmd_i = 16'h3011; cmd_valid_i = 1'b1;
    tick();
    gcd_done_i = 1'b0; cmd_valid_i = 1'b0;
    check("coincide_enables", 64'({gcd_enable_o, prep_allowed_o}), 64'd0);
    check("coincide_tx", 64'(tx_data_o), 64'h0009);
    check("coincide_px", 64'(input_px_gray_o), 64'h80);
    status_read(16'h4004);

    // Bad address and frame done, then clear on read.
    send(16'h7700);
    prep_completed_i = 1'b1;
    tick();
    prep_completed_i = 1'b0;
    status_read(16'h4030);
    status_read(16'h4000);

    // Event in the same cycle as the clearing read survives.
    prep_completed_i = 1'b1;
    status_read(16'h4000);
    prep_completed_i = 1'b0;
    status_read(16'h4020);
    status_read(16'h4000);

    // Zero operand: result passed straight through, operands persist.
    send(16'h2000); send(16'h2100);
    send(16'h2400);
    gcd_i = 16'h0012; gcd_done_i = 1'b1; sb.push_back(16'h0012);
    tick();
    gcd_done_i = 1'b0;
    check("zero_op_a", 64'(operand_a_o), 64'h0000);
    check("zero_op_b", 64'(operand_b_o), 64'h0012);

`ifdef SCHED_TIMEOUT_EN
    // Watchdog abort: enable lasts TIMEOUT_CYCLES, no result.
    p0 = n_pulse;
    send(16'h2400);
    en_cnt = 0;
    while (gcd_enable_o && en_cnt < 40) begin
      en_cnt++;
      tick();
    end
    check("timeout_len", 64'(en_cnt), 64'd16);
    check("timeout_no_pulse", 64'(n_pulse - p0), 64'd0);
    check("timeout_tx_kept", 64'(tx_data_o), 64'h0012);
    status_read(16'h4008);
`endif

    // Asynchronous reset in the middle of a job.
    send(16'h2400);
    tick();
    #2;
    nreset_i = 1'b0;
    #1;
    check("async_reset_outputs", 64'({operand_a_o, operand_b_o, gcd_enable_o, prep_allowed_o,
                                      input_px_gray_o, tx_data_o, result_valid_o}), 64'd0);
    repeat (2) tick();
    nreset_i = 1'b1;
    repeat (2) tick();
    check("after_reset_idle", 64'({gcd_enable_o, prep_allowed_o, result_valid_o}), 64'd0);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
